// File: rtl/dcache_miss_ctrl_if.sv
// Pipeline, data-array and memory-side signals of the blocking D-cache miss controller.
// slave = controller side, master = pipeline/array/memory environment.
interface dcache_miss_ctrl_if #(
  parameter int LINE_WORDS_LOG2 = 2,
  parameter int SETS_LOG2       = 6
);
  logic                       req_valid;
  logic                       req_we;
  logic [31:0]                req_addr;
  logic [31:0]                req_wdata;
  logic [3:0]                 req_be;
  logic                       miss;
  logic                       arr_we;
  logic [SETS_LOG2-1:0]       arr_index;
  logic [LINE_WORDS_LOG2-1:0] arr_word;
  logic [3:0]                 arr_be;
  logic [31:0]                arr_wdata;
  logic                       mem_req_valid;
  logic                       mem_req_ready;
  logic                       mem_req_we;
  logic [31:0]                mem_req_addr;
  logic [3:0]                 mem_req_be;
  logic [31:0]                mem_req_wdata;
  logic                       mem_rsp_valid;
  logic [31:0]                mem_rsp_data;
  logic [31:0]                perf_hits;
  logic [31:0]                perf_misses;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output miss,
    output arr_we, arr_index, arr_word, arr_be, arr_wdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output perf_hits, perf_misses
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  miss,
    input  arr_we, arr_index, arr_word, arr_be, arr_wdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  perf_hits, perf_misses
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Blocking miss controller for a direct-mapped write-through no-write-allocate D-cache.
// Read hit: 0 added cycles; miss/store stall until RESUME. Memory requests held while ready is low.
// Optional hit/miss counters enabled by defining DCACHE_CTRL_PERF_EN.
module dcache_miss_ctrl #(
  parameter int LINE_WORDS_LOG2 = 2,
  parameter int SETS_LOG2       = 6
) (
  input  logic               clk,
  input  logic               rst,
  dcache_miss_ctrl_if.slave  bus
);
  localparam int TAG_W  = 30 - LINE_WORDS_LOG2 - SETS_LOG2;
  localparam int NSETS  = 1 << SETS_LOG2;
  localparam int IDX_LO = LINE_WORDS_LOG2 + 2;
  localparam int TAG_LO = IDX_LO + SETS_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WT_REQ, S_RESUME} state_t;

  state_t                     r_state;
  logic [NSETS-1:0]           r_valid;
  logic [TAG_W-1:0]           r_tags [NSETS];
  logic [29:0]                r_addr;
  logic [3:0]                 r_be;
  logic [31:0]                r_wdata;
  logic [LINE_WORDS_LOG2-1:0] r_k;

  logic [LINE_WORDS_LOG2-1:0] w_word;
  logic [SETS_LOG2-1:0]       w_index;
  logic [TAG_W-1:0]           w_tag;
  logic [SETS_LOG2-1:0]       w_r_index;
  logic [TAG_W-1:0]           w_r_tag;
  logic                       w_idle, w_hit, w_ld_hit, w_ld_miss, w_busy_req;
  logic                       w_arr_st, w_arr_fill, w_last, w_fill_done;

  assign w_word      = bus.req_addr[IDX_LO-1:2];
  assign w_index     = bus.req_addr[TAG_LO-1:IDX_LO];
  assign w_tag       = bus.req_addr[31:TAG_LO];
  assign w_r_index   = r_addr[TAG_LO-3:IDX_LO-2];
  assign w_r_tag     = r_addr[29:TAG_LO-2];

  assign w_idle      = (r_state == S_IDLE);
  assign w_hit       = r_valid[w_index] && (r_tags[w_index] == w_tag);
  assign w_ld_hit    = w_idle && bus.req_valid && !bus.req_we && w_hit;
  assign w_ld_miss   = w_idle && bus.req_valid && !bus.req_we && !w_hit;
  assign w_busy_req  = w_idle && bus.req_valid && (bus.req_we || !w_hit);
  assign w_arr_st    = w_idle && bus.req_valid && bus.req_we && w_hit;
  assign w_arr_fill  = (r_state == S_RD_WAIT) && bus.mem_rsp_valid;
  assign w_last      = (r_k == {LINE_WORDS_LOG2{1'b1}});
  assign w_fill_done = w_arr_fill && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_k     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_busy_req) begin
            r_addr <= bus.req_addr[31:2];
            if (bus.req_we) begin
              r_be    <= bus.req_be;
              r_wdata <= bus.req_wdata;
              r_state <= S_WT_REQ;
            end else begin
              r_k     <= '0;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: if (bus.mem_req_ready) r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (bus.mem_rsp_valid) begin
            if (w_last) begin
              r_valid[w_r_index] <= 1'b1;
              r_state            <= S_RESUME;
            end else begin
              r_k     <= r_k + 1'b1;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_WT_REQ: if (bus.mem_req_ready) r_state <= S_RESUME;
        S_RESUME: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Tag contents are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_fill_done) r_tags[w_r_index] <= w_r_tag;
  end

  assign bus.miss = w_busy_req || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
                    (r_state == S_WT_REQ);

  assign bus.arr_we    = w_arr_st || w_arr_fill;
  assign bus.arr_index = w_arr_st ? w_index : (w_arr_fill ? w_r_index : '0);
  assign bus.arr_word  = w_arr_st ? w_word : (w_arr_fill ? r_k : '0);
  assign bus.arr_be    = w_arr_st ? bus.req_be : (w_arr_fill ? 4'hF : 4'h0);
  assign bus.arr_wdata = w_arr_st ? bus.req_wdata : (w_arr_fill ? bus.mem_rsp_data : 32'h0);

  // Request fields come only from latched state, so they stay stable while ready is low.
  assign bus.mem_req_valid = (r_state == S_RD_REQ) || (r_state == S_WT_REQ);
  assign bus.mem_req_we    = (r_state == S_WT_REQ);
  assign bus.mem_req_addr  = (r_state == S_RD_REQ) ? {r_addr[29:LINE_WORDS_LOG2], r_k, 2'b00} :
                             (r_state == S_WT_REQ) ? {r_addr, 2'b00} : 32'h0;
  assign bus.mem_req_be    = (r_state == S_RD_REQ) ? 4'hF :
                             (r_state == S_WT_REQ) ? r_be : 4'h0;
  assign bus.mem_req_wdata = (r_state == S_WT_REQ) ? r_wdata : 32'h0;

`ifdef DCACHE_CTRL_PERF_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else begin
      if (w_ld_hit && (r_hits != 32'hFFFF_FFFF))    r_hits   <= r_hits + 1'b1;
      if (w_ld_miss && (r_misses != 32'hFFFF_FFFF)) r_misses <= r_misses + 1'b1;
    end
  end

  assign bus.perf_hits   = r_hits;
  assign bus.perf_misses = r_misses;
`else
  logic w_perf_unused;
  assign w_perf_unused   = w_ld_hit ^ w_ld_miss;
  assign bus.perf_hits   = 32'h0;
  assign bus.perf_misses = 32'h0;
`endif
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed scenarios plus randomized accesses against a
// cache-level model (valid/tag per set, byte-addressed backing memory).
module tb_dcache_miss_ctrl;
  localparam int LW = 2;
  localparam int SL = 6;
  localparam int N  = 1 << LW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_miss_ctrl_if #(.LINE_WORDS_LOG2(LW), .SETS_LOG2(SL)) bus ();
  dcache_miss_ctrl #(.LINE_WORDS_LOG2(LW), .SETS_LOG2(SL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] mem_store [int];
  int          exp_hits, exp_misses;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int key = int'(a[31:2]);
    if (mem_store.exists(key)) return mem_store[key];
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_store[int'(a[31:2])] = w;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic check_perf(input string tag);
`ifdef DCACHE_CTRL_PERF_EN
    check_val({tag, "_perf_hits"}, bus.perf_hits, exp_hits);
    check_val({tag, "_perf_misses"}, bus.perf_misses, exp_misses);
`else
    check_val({tag, "_perf_hits"}, bus.perf_hits, 32'h0);
    check_val({tag, "_perf_misses"}, bus.perf_misses, 32'h0);
`endif
  endtask

  // Memory-side state of the bench
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  bit          aborted;
  logic [31:0] late_addr;

  // Called at a negedge; returns at a negedge with the request withdrawn.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int rdy_pct, input int max_lat,
                           input int stall0, input int rst_after);
    logic [5:0]  idx  = addr[9:4];
    logic [21:0] tag  = addr[31:10];
    bit          hit  = m_valid[idx] && (m_tag[idx] == tag);
    bit          mis  = we || !hit;
    int          exp_tx  = we ? 1 : (hit ? 0 : N);
    int          exp_arr = we ? (hit ? 1 : 0) : (hit ? 0 : N);
    int          exp_mc  = (we ? 2 : (hit ? 0 : 1 + 2 * N)) + ((mis && stall0 > 1) ? stall0 - 1 : 0);
    logic [31:0] line = {addr[31:4], 4'h0};
    int          tx_i = 0, arr_i = 0, miss_cycles = 0;
    bit          held = 1'b0, done = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic        h_we;
    logic [31:0] rsp_d = 32'h0;

    aborted = 1'b0;
    if (!we) begin
      if (hit) exp_hits++;
      else     exp_misses++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.mem_req_ready = (cyc >= stall0) && ($urandom_range(99) < rdy_pct);
      bus.mem_rsp_valid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          rsp_d             = mem_rd(pend_addr);
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rsp_data  = rsp_d;
          pend              = 1'b0;
        end else pend_cnt--;
      end
      if (rst_after >= 0 && arr_i == rst_after && bus.mem_rsp_valid) begin
        rst               = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.req_valid     = 1'b0;
        late_addr         = pend_addr;
        aborted           = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      #1;
      if (cyc == 0) check_val("miss_first", bus.miss, mis);
      if (bus.miss) miss_cycles++;
      if (held) begin
        check_val("hold_valid", bus.mem_req_valid, 1'b1);
        check_val("hold_addr", bus.mem_req_addr, h_addr);
        check_val("hold_we", bus.mem_req_we, h_we);
        check_val("hold_be", bus.mem_req_be, h_be);
        check_val("hold_wdata", bus.mem_req_wdata, h_wdata);
      end
      held    = bus.mem_req_valid && !bus.mem_req_ready;
      h_addr  = bus.mem_req_addr;
      h_we    = bus.mem_req_we;
      h_be    = bus.mem_req_be;
      h_wdata = bus.mem_req_wdata;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (tx_i >= exp_tx) check_val("tx_spurious", 1'b1, 1'b0);
        else if (we) begin
          check_val("wr_addr", bus.mem_req_addr, {addr[31:2], 2'b00});
          check_val("wr_we", bus.mem_req_we, 1'b1);
          check_val("wr_be", bus.mem_req_be, be);
          check_val("wr_data", bus.mem_req_wdata, wdata);
          mem_wr(addr, wdata, be);
        end else begin
          check_val("rd_addr", bus.mem_req_addr, line + 32'(4 * tx_i));
          check_val("rd_we", bus.mem_req_we, 1'b0);
          check_val("rd_be", bus.mem_req_be, 4'hF);
          pend      = 1'b1;
          pend_cnt  = $urandom_range(max_lat);
          pend_addr = bus.mem_req_addr;
        end
        tx_i++;
      end
      if (bus.arr_we) begin
        if (arr_i >= exp_arr) check_val("arr_spurious", 1'b1, 1'b0);
        else begin
          check_val("arr_index", bus.arr_index, idx);
          check_val("arr_word", bus.arr_word, we ? addr[3:2] : arr_i[1:0]);
          check_val("arr_be", bus.arr_be, we ? be : 4'hF);
          check_val("arr_wdata", bus.arr_wdata, we ? wdata : rsp_d);
        end
        arr_i++;
      end
      done = !bus.miss;
      @(negedge clk);
      if (done) break;
    end
    bus.req_valid     = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    if (!aborted) begin
      check_val("timeout", done, 1'b1);
      check_val("tx_count", tx_i, exp_tx);
      check_val("arr_count", arr_i, exp_arr);
      if (rdy_pct == 100 && max_lat == 0) check_val("miss_cycles", miss_cycles, exp_mc);
      if (!we && !hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_we        = 1'b0;
    bus.req_addr      = 32'h0;
    bus.req_wdata     = 32'h0;
    bus.req_be        = 4'h0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
    pend              = 1'b0;
    pend_cnt          = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_miss", bus.miss, 1'b0);
    check_val("rst_arr_we", bus.arr_we, 1'b0);
    check_val("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check_val("rst_mem_addr", bus.mem_req_addr, 32'h0);
    check_perf("rst");
    @(negedge clk);

    do_access(1'b0, 32'h0000_0100, 32'h0, 4'h0, 100, 0, 0, -1);
    do_access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 100, 0, 0, -1);
    do_access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'b0011, 100, 0, 0, -1);
    do_access(1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF, 100, 0, 0, -1);
    do_access(1'b0, 32'h0000_2000, 32'h0, 4'h0, 100, 0, 0, -1);
    do_access(1'b0, 32'h0000_2008, 32'h0, 4'h0, 100, 0, 0, -1);
    do_access(1'b0, 32'h0000_4000, 32'h0, 4'h0, 100, 0, 6, -1);
    do_access(1'b0, 32'h0000_400C, 32'h0, 4'h0, 100, 0, 0, -1);
    check_perf("directed");

    do_access(1'b0, 32'h0000_3000, 32'h0, 4'h0, 100, 0, 0, 2);
    check_val("abort_taken", aborted, 1'b1);
    model_reset();
    #1;
    check_val("abort_mem_valid", bus.mem_req_valid, 1'b0);
    check_val("abort_miss", bus.miss, 1'b0);
    check_perf("abort");
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = mem_rd(late_addr);
    #1;
    check_val("late_rsp_arr_we", bus.arr_we, 1'b0);
    check_val("late_rsp_mem_valid", bus.mem_req_valid, 1'b0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    do_access(1'b0, 32'h0000_3004, 32'h0, 4'h0, 100, 0, 0, -1);
    do_access(1'b0, 32'h0000_0104, 32'h0, 4'h0, 100, 0, 0, -1);
    do_access(1'b0, 32'h0000_3008, 32'h0, 4'h0, 100, 0, 0, -1);
    check_perf("post_abort");

    for (int i = 0; i < 160; i++) begin
      logic [31:0] a;
      logic [3:0]  b;
      a = (32'($urandom_range(3)) << 10) | (32'($urandom_range(7)) << 4) |
          (32'($urandom_range(3)) << 2);
      b = 4'($urandom_range(15, 1));
      do_access($urandom_range(3) == 0, a, $urandom, b,
                (i < 40) ? 100 : $urandom_range(100, 40), (i < 40) ? 0 : $urandom_range(3),
                0, -1);
    end
    check_perf("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
